// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode/increment controller for a time-of-day clock.
// Walks RUN -> SET_SEC .. SET_YEAR -> RUN on btn_mode. In RUN it passes
// the 1 Hz tick to the counter. In a SET state it turns btn_inc into a
// one-hot field increment, or a seconds clear. It also drives the blink
// phase for the field being edited.
// Optional feature: define SET_TIMEOUT_EN to leave set mode automatically
// after TIMEOUT_TICKS ticks with no button press.
module clock_set_ctrl #(
   parameter int TIMEOUT_TICKS = 30,
   parameter int TO_W          = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic       run_tick,
   output logic [5:0] inc_strobe,
   output logic       sec_clr,
   output logic [2:0] field_sel,
   output logic       blink
);

   typedef enum logic [2:0] {
      RUN       = 3'd0,
      SET_SEC   = 3'd1,
      SET_MIN   = 3'd2,
      SET_HOUR  = 3'd3,
      SET_DAY   = 3'd4,
      SET_MONTH = 3'd5,
      SET_YEAR  = 3'd6
   } state_t;

   state_t     state, state_next;
   logic       in_set;
   logic       inc_ok;      // increment request that is not overridden by mode
   logic       expire;      // timeout reached on this tick
   logic [5:0] inc_next;

   assign in_set = (state != RUN);
   assign inc_ok = btn_inc & ~btn_mode;

`ifdef SET_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;
   logic [TO_W-1:0] to_inc;

   assign to_inc = to_cnt + TO_W'(1);
   // A button press in the same cycle as the expiring tick wins.
   assign expire = in_set & tick_1hz & ~btn_mode & ~btn_inc
                   & (to_inc == TO_W'(TIMEOUT_TICKS));

   // Timeout counter: counts idle ticks in set mode, cleared by any activity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (!in_set || btn_mode || btn_inc || (state_next != state)) begin
         to_cnt <= '0;
      end else if (tick_1hz) begin
         to_cnt <= to_inc;
      end
   end
`else
   assign expire = 1'b0;
`endif

   // Next state and increment decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_next = state;
      inc_next   = '0;
      if (btn_mode) begin
         case (state)
            RUN:       state_next = SET_SEC;
            SET_SEC:   state_next = SET_MIN;
            SET_MIN:   state_next = SET_HOUR;
            SET_HOUR:  state_next = SET_DAY;
            SET_DAY:   state_next = SET_MONTH;
            SET_MONTH: state_next = SET_YEAR;
            default:   state_next = RUN;
         endcase
      end else if (expire) begin
         state_next = RUN;
      end
      if (inc_ok) begin
         case (state)
            SET_MIN:   inc_next = 6'b000010;
            SET_HOUR:  inc_next = 6'b000100;
            SET_DAY:   inc_next = 6'b001000;
            SET_MONTH: inc_next = 6'b010000;
            SET_YEAR:  inc_next = 6'b100000;
            default:   inc_next = 6'b000000;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state <= state_next;
      end
   end

   // Registered strobes. At most one is set, because each one is qualified by a different state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_tick   <= 1'b0;
         inc_strobe <= '0;
         sec_clr    <= 1'b0;
      end else begin
         run_tick   <= (state == RUN) & tick_1hz;
         inc_strobe <= inc_next;
         sec_clr    <= (state == SET_SEC) & inc_ok;
      end
   end

   // Blink phase: solid in RUN and after any state change, toggles per tick in set mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink <= 1'b1;
      end else if ((state_next != state) || !in_set) begin
         blink <= 1'b1;
      end else if (tick_1hz) begin
         blink <= ~blink;
      end
   end

   assign field_sel = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl. The bench computes the expected
// outputs from its own field/blink/timeout model and queues them with each
// stimulus cycle. It pops them after the clock edge and compares.
// Build with +define+SET_TIMEOUT_EN to also exercise the timeout feature.
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       run_tick;
   logic [5:0] inc_strobe;
   logic       sec_clr;
   logic [2:0] field_sel;
   logic       blink;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic       run_tick;
      logic [5:0] inc_strobe;
      logic       sec_clr;
      logic [2:0] field_sel;
      logic       blink;
   } exp_t;

   exp_t q[$];

   // Bench model of the controller.
   int   m_fs    = 0;
   logic m_blink = 1'b1;
   int   m_tc    = 0;

   clock_set_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_1hz   (tick_1hz),
      .btn_mode   (btn_mode),
      .btn_inc    (btn_inc),
      .run_tick   (run_tick),
      .inc_strobe (inc_strobe),
      .sec_clr    (sec_clr),
      .field_sel  (field_sel),
      .blink      (blink)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Run one clock cycle with the given inputs, then compare against the model.
   task automatic cyc(input logic t, input logic m, input logic i);
      exp_t e;
      int   fs_new;
      @(negedge clk);
      tick_1hz = t;
      btn_mode = m;
      btn_inc  = i;
      e.run_tick   = (m_fs == 0) && t;
      e.sec_clr    = (m_fs == 1) && i && !m;
      e.inc_strobe = ((m_fs >= 2) && i && !m) ? 6'(1 << (m_fs - 1)) : 6'd0;
      fs_new = m ? (m_fs + 1) % 7 : m_fs;
`ifdef SET_TIMEOUT_EN
      if (m_fs == 0 || m || i) m_tc = 0;
      else if (t) begin
         if (m_tc + 1 == 30) begin
            fs_new = 0;
            m_tc   = 0;
         end else begin
            m_tc = m_tc + 1;
         end
      end
`endif
      if (fs_new != m_fs || fs_new == 0) m_blink = 1'b1;
      else if (t) m_blink = ~m_blink;
      m_fs = fs_new;
      e.field_sel = 3'(m_fs);
      e.blink     = m_blink;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         check("run_tick", 32'(run_tick), 32'(e.run_tick));
         check("inc_strobe", 32'(inc_strobe), 32'(e.inc_strobe));
         check("sec_clr", 32'(sec_clr), 32'(e.sec_clr));
         check("field_sel", 32'(field_sel), 32'(e.field_sel));
         check("blink", 32'(blink), 32'(e.blink));
         check("one_hot_strobes", 32'($countones({inc_strobe, sec_clr, run_tick}) <= 1), 32'd1);
      end
   endtask

   // Apply reset for one cycle, with an optional btn_inc pending at the same time.
   task automatic do_reset(input logic inc_pending);
      @(negedge clk);
      rst_n    = 1'b0;
      btn_inc  = inc_pending;
      tick_1hz = 1'b0;
      btn_mode = 1'b0;
      @(posedge clk);
      #1;
      check("rst_run_tick", 32'(run_tick), 32'd0);
      check("rst_inc_strobe", 32'(inc_strobe), 32'd0);
      check("rst_sec_clr", 32'(sec_clr), 32'd0);
      check("rst_field_sel", 32'(field_sel), 32'd0);
      check("rst_blink", 32'(blink), 32'd1);
      @(negedge clk);
      rst_n   = 1'b1;
      btn_inc = 1'b0;
      m_fs    = 0;
      m_blink = 1'b1;
      m_tc    = 0;
      q.delete();
   endtask

   initial begin
      // Reset and ticks in RUN; the first tick is on the first edge after release.
      do_reset(1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc(1, 0, 0);
         check("run_tick_after_tick", 32'(run_tick), 32'd1);
         cyc(0, 0, 0);
         cyc(0, 0, 0);
      end
      // btn_inc ignored in RUN.
      cyc(0, 0, 1);
      cyc(0, 0, 0);

      // Three modes to SET_HOUR, two increments, and a dropped tick in between.
      for (int k = 0; k < 3; k++) cyc(0, 1, 0);
      check("fs_hour", 32'(field_sel), 32'd3);
      cyc(0, 0, 1);
      check("hour_inc_1", 32'(inc_strobe), 32'b000100);
      cyc(1, 0, 0);
      check("tick_dropped", 32'(run_tick), 32'd0);
      cyc(0, 0, 1);
      check("hour_inc_2", 32'(inc_strobe), 32'b000100);
      cyc(1, 0, 0);
      cyc(0, 0, 0);

      // Complete the cycle: DAY, MONTH, YEAR, then back to RUN.
      for (int k = 0; k < 4; k++) cyc(0, 1, 0);
      check("back_to_run", 32'(field_sel), 32'd0);

      // Seven modes give the field_sel sequence 1..6,0, with blink toggling per tick.
      for (int k = 1; k <= 7; k++) begin
         cyc(0, 1, 0);
         check("fs_seq", 32'(field_sel), 32'(k % 7));
         cyc(1, 0, 0);
         cyc(0, 0, 1);
      end

      // SET_SEC: the increment becomes sec_clr. SET_MIN: mode and inc together.
      cyc(0, 1, 0);
      cyc(0, 0, 1);
      check("sec_clr_pulse", 32'(sec_clr), 32'd1);
      cyc(0, 1, 0);
      cyc(0, 1, 1);
      check("mode_wins_fs", 32'(field_sel), 32'd3);
      check("mode_wins_inc", 32'(inc_strobe), 32'd0);
      cyc(0, 0, 0);

      // Move to SET_YEAR, then reset with an increment pending.
      for (int k = 0; k < 3; k++) cyc(0, 1, 0);
      check("fs_year", 32'(field_sel), 32'd6);
      cyc(0, 0, 1);
      check("year_inc", 32'(inc_strobe), 32'b100000);
      do_reset(1'b1);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0);
         check("no_strobe_after_rst", 32'(inc_strobe), 32'd0);
      end
      cyc(1, 0, 0);

`ifdef SET_TIMEOUT_EN
      // Enter SET_DAY and let 30 idle ticks expire.
      for (int k = 0; k < 4; k++) cyc(0, 1, 0);
      for (int k = 1; k <= 30; k++) begin
         cyc(1, 0, 0);
         check("to_fs", 32'(field_sel), (k == 30) ? 32'd0 : 32'd4);
         cyc(0, 0, 0);
      end
      check("to_blink", 32'(blink), 32'd1);
      cyc(1, 0, 0);
      check("to_run_tick", 32'(run_tick), 32'd1);
      // In SET_SEC, a button on the expiring tick wins.
      cyc(0, 1, 0);
      for (int k = 0; k < 29; k++) cyc(1, 0, 0);
      cyc(1, 0, 1);
      check("to_btn_wins", 32'(field_sel), 32'd1);
      for (int k = 0; k < 29; k++) cyc(1, 0, 0);
      check("to_still_set", 32'(field_sel), 32'd1);
      cyc(1, 0, 0);
      check("to_expire2", 32'(field_sel), 32'd0);
`endif

      cyc(0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 30, meaning tick_1hz pulses without a button press before auto-exit from set mode.
REQ-002 SHALL have parameter TO_W, default 6, meaning timeout counter width; TIMEOUT_TICKS < 2**TO_W.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port tick_1hz, input, 1 bit: one-cycle 1 Hz enable from the prescaler.
REQ-006 SHALL have port btn_mode, input, 1 bit: one-cycle debounced mode-button pulse.
REQ-007 SHALL have port btn_inc, input, 1 bit: one-cycle debounced increment-button pulse.
REQ-008 SHALL have port run_tick, output, 1 bit: count-enable pulse to the time/date counter.
REQ-009 SHALL have port inc_strobe, output, 6 bits: one-hot field increment; bit0 sec, bit1 min, bit2 hour, bit3 day, bit4 month, bit5 year.
REQ-010 SHALL have port sec_clr, output, 1 bit: one-cycle seconds-clear pulse.
REQ-011 SHALL have port field_sel, output, 3 bits: 0 none, 1 sec, 2 min, 3 hour, 4 day, 5 month, 6 year.
REQ-012 SHALL have port blink, output, 1 bit: display blank request for the selected field, 1 = show.

Function
REQ-013 SHALL implement FSM states RUN, SET_SEC, SET_MIN, SET_HOUR, SET_DAY, SET_MONTH, SET_YEAR.
REQ-014 SHALL advance RUN->SET_SEC->SET_MIN->SET_HOUR->SET_DAY->SET_MONTH->SET_YEAR->RUN, one step per btn_mode pulse.
REQ-015 SHALL drive field_sel combinationally from state: RUN=0, SET_SEC=1 ... SET_YEAR=6.
REQ-016 SHALL, in RUN, register tick_1hz to run_tick, giving exactly 1 cycle latency.
REQ-017 SHALL hold run_tick at 0 in every SET state; ticks arriving then are dropped, not buffered.
REQ-018 SHALL, in SET_MIN..SET_YEAR, register btn_inc to the inc_strobe bit of the selected field, 1 cycle latency; other bits stay 0.
REQ-019 SHALL, in SET_SEC, turn btn_inc into a registered sec_clr pulse instead of an inc_strobe.
REQ-020 SHALL ignore btn_inc in RUN.
REQ-021 SHALL, when btn_mode and btn_inc arrive in the same cycle, take the mode transition and drop the increment.
REQ-022 SHALL toggle blink on each tick_1hz in SET states, and hold blink at 1 in RUN.
REQ-023 SHALL force blink to 1 on every state change.
REQ-024 SHALL never assert more than one of inc_strobe bits, sec_clr and run_tick in the same cycle.

Reset
REQ-025 SHALL, while rst_n=0, force state RUN, run_tick=0, inc_strobe=0, sec_clr=0, blink=1, timeout counter 0.
REQ-026 SHALL, on reset asserted mid set-operation, abort immediately with no pending strobe issued after release.
REQ-027 SHALL act on the first tick or button in the first clock edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with SET_TIMEOUT_EN defined, count tick_1hz in SET states.
REQ-029 SHALL, with SET_TIMEOUT_EN defined, clear the timeout count on any btn_mode, btn_inc or state change.
REQ-030 SHALL, with SET_TIMEOUT_EN defined, return to RUN with blink=1 on the tick that makes the count equal TIMEOUT_TICKS.
REQ-031 SHALL, with SET_TIMEOUT_EN defined, let a button pulse in the same cycle as the expiring tick win and clear the count.
REQ-032 SHALL, without SET_TIMEOUT_EN, contain no timeout counter and leave set mode only via btn_mode.

Verification
REQ-033 SHALL cover: reset, 3 ticks in RUN -> 3 run_tick pulses, each 1 cycle after its tick; field_sel=0; blink=1.
REQ-034 SHALL cover: 3 btn_mode then 2 btn_inc -> field_sel=3, inc_strobe=6'b000100 twice, run_tick=0 for ticks in that window.
REQ-035 SHALL cover: 7 btn_mode pulses -> state returns to RUN; field_sel sequence 1,2,3,4,5,6,0.
REQ-036 SHALL cover: btn_mode and btn_inc same cycle in SET_MIN -> field_sel=3, no inc_strobe.
REQ-037 SHALL cover, with SET_TIMEOUT_EN: enter SET_DAY, 30 ticks with no button -> RUN on tick 30, blink=1, next tick gives run_tick.
REQ-038 SHALL cover: rst_n low for 1 cycle while in SET_YEAR with btn_inc pending -> RUN, no inc_strobe ever issued.
